// File: rtl/q2a03_bus_pkg.sv
// Shared types and constants for the Q2A03 CPU bus: region decode, the
// responder state machine encoding, and the register typedefs used by the CPU.
package q2a03_bus_pkg;

  typedef logic [7:0]  reg8_type;
  typedef logic [15:0] reg16_type;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_JOY1,
    REGION_JOY2,
    REGION_NONE
  } region_type;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    COMMIT
  } state_type;

  localparam reg16_type JOY1_ADDR_DEFAULT = 16'h4016;
  localparam reg16_type JOY2_ADDR_DEFAULT = 16'h4017;

  // Work RAM covers the whole $0000-$1FFF window; the RAM itself mirrors it.
  function automatic region_type decode_region(input reg16_type addr,
                                               input reg16_type joy1,
                                               input reg16_type joy2);
    if (addr[15:13] == 3'b000) return REGION_RAM;
    else if (addr == joy1)     return REGION_JOY1;
    else if (addr == joy2)     return REGION_JOY2;
    else                       return REGION_NONE;
  endfunction

endpackage

// File: rtl/q2a03_ram_2k.sv
// Single-port synchronous work RAM: one-clock read latency, write enable,
// output register holds its value while rd_en is low.
module q2a03_ram_2k #(
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           wr_data,
  output logic [7:0]           rd_data
);

  logic [7:0] mem [0:(1<<ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
    if (rd_en) rd_data <= mem[addr];
  end

endmodule

// File: rtl/q2a03_bus_responder.sv
// CPU-bus responder: captures each phy2 bus cycle, serves work RAM, the two
// controller shift registers and open-bus reads, and commits after phy2 falls.
module q2a03_bus_responder
  import q2a03_bus_pkg::*;
#(
  parameter int        RAM_ADDR_BITS = 11,
  parameter reg16_type JOY1_ADDR     = JOY1_ADDR_DEFAULT,
  parameter reg16_type JOY2_ADDR     = JOY2_ADDR_DEFAULT,
  parameter reg8_type  OPEN_BUS_INIT = 8'h00
) (
  input  logic        G_clock,
  input  logic        G_reset,
  input  logic        G_phy2,
  input  logic [15:0] G_addr,
  input  logic        G_rdwr,
  input  logic [7:0]  G_wr_data,
  output logic [7:0]  G_rd_data,
  input  logic [7:0]  pad1_buttons,
  input  logic [7:0]  pad2_buttons,
  output logic        pad_strobe
);

  state_type  state_q, state_d;
  region_type region;
  logic       phy2_q, rise, fall;
  reg16_type  addr_q;
  logic       rdwr_q;
  reg8_type   wr_data_q;
  reg8_type   sr1, sr2, open_bus, ram_q, rd_next;
  logic       joy1_bit, joy2_bit, commit, ram_wr;

  assign rise   = G_phy2 & ~phy2_q;
  assign fall   = ~G_phy2 & phy2_q;
  assign region = decode_region(addr_q, JOY1_ADDR, JOY2_ADDR);
  assign commit = (state_q == COMMIT);
  assign ram_wr = commit & ~rdwr_q & (region == REGION_RAM);

  q2a03_ram_2k #(.ADDR_BITS(RAM_ADDR_BITS)) u_ram (
    .clk     (G_clock),
    .rd_en   (state_q == ADDR),
    .wr_en   (ram_wr),
    .addr    (addr_q[RAM_ADDR_BITS-1:0]),
    .wr_data (wr_data_q),
    .rd_data (ram_q)
  );

  // A rise restarts the cycle from any state; a fall only matters in DATA.
  always_comb begin
    state_d = state_q;
    if (rise) begin
      state_d = ADDR;
    end else begin
      case (state_q)
        ADDR:    state_d = DATA;
        DATA:    if (fall) state_d = COMMIT;
        COMMIT:  state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    joy1_bit = pad_strobe ? pad1_buttons[0] : sr1[0];
    joy2_bit = pad_strobe ? pad2_buttons[0] : sr2[0];
    rd_next  = open_bus;
    case (region)
      REGION_RAM:  rd_next = ram_q;
      REGION_JOY1: rd_next = {open_bus[7:5], 4'b0000, joy1_bit};
      REGION_JOY2: rd_next = {open_bus[7:5], 4'b0000, joy2_bit};
      default:     rd_next = open_bus;
    endcase
  end

  always_ff @(posedge G_clock) begin
    phy2_q <= G_phy2;
    if (G_reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rdwr_q     <= 1'b1;
      wr_data_q  <= '0;
      G_rd_data  <= OPEN_BUS_INIT;
      open_bus   <= OPEN_BUS_INIT;
      pad_strobe <= 1'b0;
      sr1        <= 8'hFF;
      sr2        <= 8'hFF;
    end else begin
      state_q <= state_d;
      if (rise) begin
        addr_q    <= G_addr;
        rdwr_q    <= G_rdwr;
        wr_data_q <= G_wr_data;
      end
      if (state_q == DATA && rdwr_q) G_rd_data <= rd_next;
      if (commit) begin
        if (!rdwr_q) begin
          if (region == REGION_JOY1) pad_strobe <= wr_data_q[0];
          open_bus <= wr_data_q;
        end else begin
          open_bus <= G_rd_data;
        end
      end
      // Strobe high keeps reloading, including the clock that clears it.
      if (pad_strobe) begin
        sr1 <= pad1_buttons;
        sr2 <= pad2_buttons;
      end else if (commit && rdwr_q) begin
        if (region == REGION_JOY1) sr1 <= {1'b1, sr1[7:1]};
        if (region == REGION_JOY2) sr2 <= {1'b1, sr2[7:1]};
      end
    end
  end

endmodule

// File: tb/tb_q2a03_bus_responder.sv
// Self-checking bench for q2a03_bus_responder: table of bus cycles with a
// read-data scoreboard, plus hand-written strobe and reset sequences.
module tb_q2a03_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        phy2;
  logic [15:0] addr;
  logic        rdwr;
  logic [7:0]  wdata;
  logic [7:0]  rd_data;
  logic [7:0]  pad1, pad2;
  logic        strobe;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [15:0] addr;
    logic        rdwr;
    logic [7:0]  wdata;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[19];
  logic [7:0] model [0:2047];

  q2a03_bus_responder dut (
    .G_clock      (clk),
    .G_reset      (rst),
    .G_phy2       (phy2),
    .G_addr       (addr),
    .G_rdwr       (rdwr),
    .G_wr_data    (wdata),
    .G_rd_data    (rd_data),
    .pad1_buttons (pad1),
    .pad2_buttons (pad2),
    .pad_strobe   (strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full phy2 period: 4 clocks high, sample just before the fall, 4 low.
  task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                           input logic [7:0] exp, input string name);
    logic [7:0] e;
    @(negedge clk);
    addr = a; rdwr = rw; wdata = wd; phy2 = 1'b1;
    if (rw) exp_q.push_back(exp);
    repeat (4) @(negedge clk);
    if (rw) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL %s: scoreboard empty", name);
      end else begin
        e = exp_q.pop_front();
        check(name, rd_data, e);
      end
    end
    phy2 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [15:0] ra [6];
    logic [7:0]  rv [6];
    logic [7:0]  saved;
    logic [1:0]  mir;

    vecs[0]  = '{16'h0123, 1'b0, 8'hA5, 8'h00};
    vecs[1]  = '{16'h0923, 1'b1, 8'h00, 8'hA5};
    vecs[2]  = '{16'h1923, 1'b1, 8'h00, 8'hA5};
    vecs[3]  = '{16'h4016, 1'b0, 8'h01, 8'h00};
    vecs[4]  = '{16'h4016, 1'b0, 8'h00, 8'h00};
    vecs[5]  = '{16'h4016, 1'b1, 8'h00, 8'h01};
    vecs[6]  = '{16'h4016, 1'b1, 8'h00, 8'h00};
    vecs[7]  = '{16'h4016, 1'b1, 8'h00, 8'h00};
    vecs[8]  = '{16'h4016, 1'b1, 8'h00, 8'h00};
    vecs[9]  = '{16'h4016, 1'b1, 8'h00, 8'h00};
    vecs[10] = '{16'h4016, 1'b1, 8'h00, 8'h00};
    vecs[11] = '{16'h4016, 1'b1, 8'h00, 8'h00};
    vecs[12] = '{16'h4016, 1'b1, 8'h00, 8'h01};
    vecs[13] = '{16'h4016, 1'b1, 8'h00, 8'h01};
    vecs[14] = '{16'h4016, 1'b1, 8'h00, 8'h01};
    vecs[15] = '{16'h0000, 1'b0, 8'h5C, 8'h00};
    vecs[16] = '{16'h0000, 1'b1, 8'h00, 8'h5C};
    vecs[17] = '{16'h5000, 1'b1, 8'h00, 8'h5C};
    vecs[18] = '{16'h4017, 1'b1, 8'h00, 8'h40};

    rst = 1'b1; phy2 = 1'b0; addr = '0; rdwr = 1'b1; wdata = '0;
    pad1 = 8'b1000_0001; pad2 = 8'hFE;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_rd_data", rd_data, 8'h00);
    check("reset_strobe", {7'b0, strobe}, 8'h00);

    for (int i = 0; i < 19; i++)
      bus_cycle(vecs[i].addr, vecs[i].rdwr, vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i));

    // Random RAM traffic through random mirrors.
    for (int i = 0; i < 6; i++) begin
      mir   = 2'($urandom_range(0, 3));
      ra[i] = {3'b000, mir, 11'($urandom_range(0, 2047))};
      rv[i] = 8'($urandom_range(0, 255));
      model[ra[i][10:0]] = rv[i];
      bus_cycle(ra[i], 1'b0, rv[i], 8'h00, "ram_wr");
    end
    for (int i = 0; i < 6; i++) begin
      mir = 2'($urandom_range(0, 3));
      bus_cycle({3'b000, mir, ra[i][10:0]}, 1'b1, 8'h00, model[ra[i][10:0]],
                $sformatf("ram_rd%0d", i));
    end

    // Strobe high: reads follow the live A bit and never shift.
    bus_cycle(16'h4016, 1'b0, 8'h01, 8'h00, "strobe_on");
    check("strobe_set", {7'b0, strobe}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      pad1 = 8'($urandom_range(0, 255));
      pad1[0] = ~i[0];
      bus_cycle(16'h4016, 1'b1, 8'h00, {7'b0, pad1[0]}, $sformatf("live%0d", i));
    end
    pad1 = 8'($urandom_range(0, 255));
    pad1[0] = 1'b1;
    saved = pad1;
    bus_cycle(16'h4016, 1'b0, 8'h00, 8'h00, "strobe_off");
    pad1 = ~saved;
    bus_cycle(16'h4016, 1'b1, 8'h00, {7'b0, saved[0]}, "latched_a");
    bus_cycle(16'h4016, 1'b1, 8'h00, {7'b0, saved[1]}, "latched_b");

    // Reset in ADDR of a RAM write; release with phy2 still high.
    bus_cycle(16'h0010, 1'b0, 8'h33, 8'h00, "pre_wr");
    bus_cycle(16'h4016, 1'b0, 8'h01, 8'h00, "strobe_on2");
    @(negedge clk);
    addr = 16'h0010; rdwr = 1'b0; wdata = 8'h77; phy2 = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_strobe", {7'b0, strobe}, 8'h00);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    phy2 = 1'b0;
    repeat (4) @(negedge clk);
    check("no_spurious_rd", rd_data, 8'h00);
    check("no_spurious_strobe", {7'b0, strobe}, 8'h00);
    bus_cycle(16'h5000, 1'b1, 8'h00, 8'h00, "open_bus_after_rst");
    bus_cycle(16'h0010, 1'b1, 8'h00, 8'h33, "ram_intact");

    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries remain, 0 expected", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/q2a03_bus_responder.md
Name: q2a03_bus_responder

Overview:
- Bus-side responder for the Q2A03 CPU bus: decodes each CPU bus cycle and serves the 2 KiB internal work RAM (mirrored), the two controller ports at $4016/$4017, and open-bus reads.
- Samples the address at the phy2 rising edge and drives G_rd_data before the CPU samples it at the phy2 falling edge.
- Commits writes and read side-effects at the phy2 falling edge.
- Sits between the CPU core and the cartridge/PPU decode, as the counterpart to the CPU's bus initiator.

Parameters:
- RAM_ADDR_BITS, 11, work-RAM address width; RAM is mirrored through $0000-$1FFF.
- JOY1_ADDR, 16'h4016, controller 1 read / strobe write address.
- JOY2_ADDR, 16'h4017, controller 2 read address; writes here are ignored.
- OPEN_BUS_INIT, 8'h00, open-bus latch value after reset.

Ports:
- G_clock  in  1  system clock; the only clock.
- G_reset  in  1  synchronous, active-high reset.
- G_phy2  in  1  CPU phase-2 level; at least 3 G_clock cycles high and 3 low.
- G_addr  in  16  CPU address.
- G_rdwr  in  1  1 = read, 0 = write.
- G_wr_data  in  8  CPU write data.
- G_rd_data  out  8  read data to the CPU.
- pad1_buttons  in  8  live controller 1 state; bit0 = A, then B, Select, Start, Up, Down, Left, Right.
- pad2_buttons  in  8  live controller 2 state, same bit order.
- pad_strobe  out  1  current strobe latch; fans out to the controller hardware.

Behaviour:
- **Reset** (G_reset=1 at a G_clock edge):
  - G_rd_data=OPEN_BUS_INIT, pad_strobe=0, both shift registers=8'hFF, open-bus latch=OPEN_BUS_INIT.
  - phy2_q is loaded with G_phy2 so that no edge is seen on the first cycle after reset.
  - Any in-flight access is dropped. RAM contents are not cleared.
- **Edge detect:**
  - rise = G_phy2 & ~phy2_q; fall = ~G_phy2 & phy2_q.
  - phy2_q <= G_phy2 every clock.
- **Address/control capture:** on the rise clock, latch addr_q, rdwr_q and wr_data_q.
  - Region decode uses addr_q only: RAM when addr_q[15:13]==0; JOY1; JOY2; otherwise unmapped.
- **State machine:** IDLE -> (rise) ADDR -> (next clock) DATA -> (fall) COMMIT -> (next clock) IDLE.
  - A rise seen in any state other than IDLE restarts at ADDR.
  - A fall seen in IDLE is ignored.
- **Read path:**
  - ADDR issues a synchronous RAM read of addr_q[RAM_ADDR_BITS-1:0].
  - In DATA, G_rd_data is loaded with the result:
    - RAM: the RAM output.
    - JOY1: {open_bus[7:5], 4'b0000, bit}, where bit = pad1_buttons[0] if pad_strobe else sr1[0].
    - JOY2: the same using pad2_buttons / sr2.
    - Unmapped: the open-bus latch.
  - G_rd_data is therefore valid 2 clocks after rise and holds until the next DATA state.
- **COMMIT** (fall clock):
  - Write:
    - RAM: write wr_data_q to RAM[addr_q[10:0]].
    - JOY1: pad_strobe <= wr_data_q[0].
    - Update the open-bus latch with wr_data_q.
  - Read:
    - If JOY1/JOY2 and pad_strobe==0, shift the matching register right with 1 entering bit7, so the 9th and later reads return 1.
    - Update the open-bus latch with G_rd_data.
  - Writes to JOY2 or unmapped addresses have no effect except on the open-bus latch.
- **Strobe reload:** every clock while pad_strobe==1, sr1 <= pad1_buttons and sr2 <= pad2_buttons.
  - On a 1->0 strobe write, the reload still happens in the COMMIT clock, so the registers hold the button state from that clock.
- **Simultaneous events:**
  - Reset has priority over everything.
  - A read of $4016 with strobe=1 never shifts.
  - A RAM write followed by a read of the same address in the next bus cycle returns the new data.

Decomposition:
- Package q2a03_bus_pkg:
  - region enum (REGION_RAM, REGION_JOY1, REGION_JOY2, REGION_NONE);
  - state enum (IDLE, ADDR, DATA, COMMIT);
  - JOY1/JOY2 address constants;
  - reg8_type / reg16_type typedefs, shared with the CPU.
- One sub-module, q2a03_ram_2k: single-port synchronous RAM with 1-clock read latency and a write enable; inferable as block RAM.

Test Plan:
- Write 8'hA5 to $0123 then read $0923 (mirror) -> G_rd_data=8'hA5 at the phy2 fall; also read $1923 -> 8'hA5.
- pad1_buttons=8'b1000_0001; write $4016=1, write $4016=0, then 10 reads of $4016 -> low bits 1,0,0,0,0,0,0,1,1,1.
- pad_strobe=1, pad1_buttons bit0 toggling between reads; 3 reads of $4016 -> each returns live bit0, no shift (after strobe=0, the first read still returns the current A).
- Read $0000 returning 8'h5C, then read $5000 (unmapped) -> 8'h5C; read $4017 with sr2[0]=0 -> 8'h40.
- Assert G_reset during ADDR of a RAM write to $0010 -> no write occurs; G_rd_data=8'h00, pad_strobe=0; an earlier RAM value at $0010 is intact.
- Reset released while G_phy2=1 -> no spurious access; the first access happens only after the next rise.
